// File: rtl/settings_pkg.sv
// Shared types for the traffic test path: test modes, packet format, sequencer state and status.
package settings_pkg;

  localparam int AMM_ADDR_W  = 16;
  localparam int AMM_BURST_W = 8;
  localparam int ADDR_B_W    = 2;

  typedef enum logic [1:0] {
    READ_ONLY       = 2'd0,
    WRITE_ONLY      = 2'd1,
    WRITE_AND_CHECK = 2'd2
  } test_mode_t;

  typedef struct packed {
    logic                   pkt_type;        // 0 = write, 1 = read
    logic [AMM_ADDR_W-1:0]  word_addr;
    logic [ADDR_B_W-1:0]    end_offset;
    logic [ADDR_B_W-1:0]    start_offset;
    logic [AMM_BURST_W-1:0] low_burst_bits;  // burst length minus one
  } trans_struct_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PASS = 3'd1,
    GAP     = 3'd2,
    RD_PASS = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    SEQ_OK      = 2'd0,
    SEQ_ERROR   = 2'd1,
    SEQ_ABORT   = 2'd2,
    SEQ_TIMEOUT = 2'd3
  } seq_status_t;

endpackage

// File: rtl/test_sequencer.sv
// Test controller: issues write/read burst packets over an address window, then drains and reports status.
// Optional stall watchdog enabled by defining SEQ_TIMEOUT_EN.
module test_sequencer
  import settings_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int TMO_W  = 16,
  parameter int ADDR_W = AMM_ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_stb_i,
  input  logic                   abort_stb_i,
  input  test_mode_t             test_mode_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [CNT_W-1:0]       pkt_count_i,
  input  logic [AMM_BURST_W-1:0] burst_words_i,
  input  logic [2*ADDR_B_W-1:0]  offsets_i,
  input  logic                   cmd_accept_ready_i,
  input  logic                   trans_block_busy_i,
  input  logic                   error_check_i,
  output logic                   op_valid_o,
  output trans_struct_t          op_pkt_o,
  output logic                   busy_o,
  output logic                   done_stb_o,
  output seq_status_t            status_o,
  output logic [CNT_W-1:0]       pkt_done_o
);

  seq_state_t             state;
  test_mode_t             mode;
  logic [ADDR_W-1:0]      base;
  logic [ADDR_W-1:0]      addr;
  logic [CNT_W-1:0]       count;
  logic [AMM_BURST_W-1:0] burst;
  logic [2*ADDR_B_W-1:0]  offsets;

  logic fault;
  logic last_pkt;
  logic tmo_hit;

  assign fault    = (error_check_i || abort_stb_i) && (state != IDLE);
  assign last_pkt = (pkt_done_o + CNT_W'(1)) == count;
  assign busy_o   = (state != IDLE);

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
  logic             stall;

  assign stall   = (op_valid_o && !cmd_accept_ready_i) ||
                   (((state == GAP) || (state == DRAIN)) && trans_block_busy_i);
  // Fires on the stalled edge that would bring the counter to all-ones.
  assign tmo_hit = stall && (tmo == {{(TMO_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo <= '0;
    end else if (stall && !fault && !tmo_hit) begin
      tmo <= tmo + TMO_W'(1);
    end else begin
      tmo <= '0;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_W;
`endif

  always_comb begin
    op_pkt_o                = '0;
    op_pkt_o.pkt_type       = (state == RD_PASS);
    op_pkt_o.word_addr      = AMM_ADDR_W'(addr);
    op_pkt_o.end_offset     = offsets[2*ADDR_B_W-1:ADDR_B_W];
    op_pkt_o.start_offset   = offsets[ADDR_B_W-1:0];
    op_pkt_o.low_burst_bits = burst - AMM_BURST_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      op_valid_o <= 1'b0;
      done_stb_o <= 1'b0;
      status_o   <= SEQ_OK;
      pkt_done_o <= '0;
      mode       <= READ_ONLY;
      base       <= '0;
      addr       <= '0;
      count      <= '0;
      burst      <= '0;
      offsets    <= '0;
    end else begin
      done_stb_o <= 1'b0;
      if (state == IDLE) begin
        if (start_stb_i) begin
          mode       <= test_mode_i;
          base       <= base_addr_i;
          addr       <= base_addr_i;
          count      <= pkt_count_i;
          burst      <= burst_words_i;
          offsets    <= offsets_i;
          status_o   <= SEQ_OK;
          pkt_done_o <= '0;
          if (pkt_count_i == '0)
            state <= DRAIN;
          else if (test_mode_i == READ_ONLY)
            state <= RD_PASS;
          else
            state <= WR_PASS;
        end
      end else if (fault) begin
        // Error outranks abort and outranks a same-cycle acceptance.
        op_valid_o <= 1'b0;
        state      <= DRAIN;
        if (status_o == SEQ_OK)
          status_o <= error_check_i ? SEQ_ERROR : SEQ_ABORT;
      end else if (tmo_hit) begin
        op_valid_o <= 1'b0;
        done_stb_o <= 1'b1;
        state      <= IDLE;
        if (status_o == SEQ_OK)
          status_o <= SEQ_TIMEOUT;
      end else begin
        case (state)
          WR_PASS, RD_PASS: begin
            if (!op_valid_o) begin
              op_valid_o <= 1'b1;
            end else if (cmd_accept_ready_i) begin
              pkt_done_o <= pkt_done_o + CNT_W'(1);
              addr       <= addr + ADDR_W'(burst);
              if (last_pkt) begin
                op_valid_o <= 1'b0;
                state <= ((state == WR_PASS) && (mode == WRITE_AND_CHECK)) ? GAP : DRAIN;
              end
            end
          end
          GAP: begin
            if (!trans_block_busy_i) begin
              pkt_done_o <= '0;
              addr       <= base;
              state      <= RD_PASS;
            end
          end
          DRAIN: begin
            if (!trans_block_busy_i) begin
              done_stb_o <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: vector table, randomized runs against a packet-list model,
// and directed corner sequences (SEQ_TIMEOUT_EN adds a watchdog sequence).
module tb_test_sequencer;
  import settings_pkg::*;

`ifdef SEQ_TIMEOUT_EN
  localparam int TB_TMO_W = 4;
`else
  localparam int TB_TMO_W = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, err = 1'b0;
  test_mode_t    mode = READ_ONLY;
  logic [15:0]   base = '0;
  logic [31:0]   count = '0;
  logic [7:0]    burst = 8'd1;
  logic [3:0]    offs = '0;
  logic          ready = 1'b0, tbusy = 1'b0;
  logic          op_valid, busy, done_stb;
  trans_struct_t op_pkt;
  seq_status_t   status;
  logic [31:0]   pkt_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_sequencer #(.CNT_W(32), .TMO_W(TB_TMO_W), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_stb_i(start), .abort_stb_i(abort),
    .test_mode_i(mode), .base_addr_i(base), .pkt_count_i(count), .burst_words_i(burst),
    .offsets_i(offs), .cmd_accept_ready_i(ready), .trans_block_busy_i(tbusy),
    .error_check_i(err), .op_valid_o(op_valid), .op_pkt_o(op_pkt), .busy_o(busy),
    .done_stb_o(done_stb), .status_o(status), .pkt_done_o(pkt_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input test_mode_t m, input logic [15:0] b, input int cnt, input logic [7:0] bw);
    @(negedge clk);
    mode = m; base = b; count = 32'(cnt); burst = bw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (done_stb) found = 1;
      else @(negedge clk);
    end
    chk(name, found, 1);
    @(negedge clk);
  endtask

  // Runs one test; the expected packet list is built up front from base + k*burst.
  task automatic run_test(input test_mode_t m, input logic [15:0] b, input int cnt, input logic [7:0] bw,
                          input int rdy_mode, input int bsy_mode,
                          output int n_acc, output logic [15:0] last_a, output int span);
    trans_struct_t exp_q[$];
    trans_struct_t t, prev_pkt;
    logic prev_stall = 1'b0;
    logic [3:0] o;
    int passes, first_c = -1, last_c = -1;
    bit fin = 0;
    o = 4'($urandom);
    passes = (m == WRITE_AND_CHECK) ? 2 : 1;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < cnt; k++) begin
        t.pkt_type       = (m == READ_ONLY) || (p == 1);
        t.word_addr      = 16'(int'(b) + k * int'(bw));
        t.end_offset     = o[3:2];
        t.start_offset   = o[1:0];
        t.low_burst_bits = bw - 8'd1;
        exp_q.push_back(t);
      end
    n_acc = 0; last_a = '0; prev_pkt = '0;
    @(negedge clk);
    mode = m; base = b; count = 32'(cnt); burst = bw; offs = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom);
      tbusy = (bsy_mode != 0) && ($urandom_range(2) == 0);
      if (done_stb) begin
        fin = 1;
        chk("status_ok", status, SEQ_OK);
        chk("busy_at_done", busy, 0);
        chk("pkt_done_end", pkt_done, 32'(cnt));
        break;
      end
      if (op_valid && prev_stall) chk("pkt_stable", op_pkt, prev_pkt);
      if (op_valid && ready) begin
        chk("pkt_done_pre", pkt_done, (cnt > 0) ? 32'(n_acc % cnt) : 32'd0);
        if (exp_q.size() == 0) chk("extra_pkt", 1, 0);
        else begin
          t = exp_q.pop_front();
          chk("pkt", op_pkt, t);
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        n_acc++;
        last_a = op_pkt.word_addr;
      end
      prev_stall = op_valid && !ready;
      prev_pkt   = op_pkt;
      @(negedge clk);
    end
    tbusy = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    chk("model_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_once", done_stb, 0);
    chk("valid_idle", op_valid, 0);
    span = (first_c < 0) ? 0 : last_c - first_c;
    $display("test mode=%0d base=%h count=%0d burst=%0d accepts=%0d last=%h", m, b, cnt, bw, n_acc, last_a);
  endtask

  typedef struct {
    test_mode_t  m;
    logic [15:0] b;
    int          cnt;
    logic [7:0]  bw;
    int          rdy;
    int          bsy;
    int          exp_acc;
    logic [15:0] exp_last;
    int          exp_span;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, sp, m_rd, dn, c;
    logic [15:0] la;
    test_mode_t rm;
    logic [15:0] rb;
    int rc;
    logic [7:0] rw;

    vecs[0] = '{WRITE_ONLY,      16'h0100, 4, 8'd8, 0, 0, 4,  16'h0118, 3};
    vecs[1] = '{WRITE_AND_CHECK, 16'h0040, 3, 8'd2, 2, 1, 6,  16'h0044, -1};
    vecs[2] = '{READ_ONLY,       16'h0200, 5, 8'd3, 1, 0, 5,  16'h020C, -1};
    vecs[3] = '{WRITE_ONLY,      16'hFFFC, 2, 8'd4, 0, 0, 2,  16'h0000, 1};
    vecs[4] = '{READ_ONLY,       16'h0010, 0, 8'd4, 0, 1, 0,  16'h0000, -1};
    vecs[5] = '{WRITE_AND_CHECK, 16'hFFF0, 5, 8'd7, 2, 1, 10, 16'h000C, -1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", op_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_stb, 0);
    chk("rst_status", status, SEQ_OK);
    chk("rst_pkt_done", pkt_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_test(vecs[i].m, vecs[i].b, vecs[i].cnt, vecs[i].bw, vecs[i].rdy, vecs[i].bsy, n, la, sp);
      chk("accepts", n, vecs[i].exp_acc);
      chk("last_addr", la, vecs[i].exp_last);
      if (vecs[i].exp_span >= 0) chk("span", sp, vecs[i].exp_span);
    end

    for (int i = 0; i < 10; i++) begin
      rm = test_mode_t'($urandom_range(2));
      rb = 16'($urandom);
      rc = $urandom_range(6);
      rw = 8'($urandom_range(255, 1));
      run_test(rm, rb, rc, rw, 2, 1, n, la, sp);
      chk("rand_accepts", n, rc * ((rm == WRITE_AND_CHECK) ? 2 : 1));
      chk("rand_last", la, (rc > 0) ? 16'(int'(rb) + (rc - 1) * int'(rw)) : 16'h0);
    end

    // Reads held off while the transmitter is still busy after the writes
    ready = 1'b1; tbusy = 1'b0;
    pulse_start(WRITE_AND_CHECK, 16'h0300, 3, 8'd2);
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      if (op_valid) n++;
      @(negedge clk);
    end
    tbusy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("gap_hold", op_valid, 0);
    end
    tbusy = 1'b0;
    m_rd = 0;
    for (int k = 0; k < 20 && m_rd < 3; k++) begin
      if (op_valid) begin
        chk("gap_rd_addr", op_pkt.word_addr, 16'(16'h0300 + 2 * m_rd));
        chk("gap_rd_type", op_pkt.pkt_type, 1);
        m_rd++;
      end
      @(negedge clk);
    end
    chk("gap_reads", m_rd, 3);
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_stb) dn++;
      @(negedge clk);
    end
    chk("gap_done_count", dn, 1);
    $display("seq gap_hold reads=%0d done_pulses=%0d", m_rd, dn);

    // Error on the cycle of the second acceptance
    ready = 1'b1;
    pulse_start(WRITE_ONLY, 16'h0000, 6, 8'd1);
    c = 0;
    while (!(op_valid && pkt_done == 32'd1) && c < 20) begin
      @(negedge clk);
      c++;
    end
    err = 1'b1;
    @(negedge clk);
    err = 1'b0; tbusy = 1'b1;
    chk("err_pkt_done", pkt_done, 1);
    chk("err_status", status, SEQ_ERROR);
    chk("err_valid", op_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("err_no_valid", op_valid, 0);
      chk("err_no_done", done_stb, 0);
    end
    tbusy = 1'b0;
    wait_done("err_done");
    chk("err_status_held", status, SEQ_ERROR);
    $display("seq error_on_accept2 status=%0d pkt_done=%0d", status, pkt_done);

    // Start ignored while running; abort sticks; later error cannot overwrite it
    ready = 1'b0;
    pulse_start(WRITE_ONLY, 16'h0500, 10, 8'd4);
    chk("status_cleared", status, SEQ_OK);
    @(negedge clk);
    chk("ign_valid", op_valid, 1);
    mode = READ_ONLY; base = 16'h0700; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_type", op_pkt.pkt_type, 0);
    chk("ign_addr", op_pkt.word_addr, 16'h0500);
    abort = 1'b1; tbusy = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_status", status, SEQ_ABORT);
    chk("abort_valid", op_valid, 0);
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    chk("abort_sticky", status, SEQ_ABORT);
    tbusy = 1'b0;
    wait_done("abort_done");
    $display("seq abort status=%0d", status);

    // Error and abort together: error wins
    pulse_start(READ_ONLY, 16'h0020, 4, 8'd1);
    chk("status_cleared2", status, SEQ_OK);
    @(negedge clk);
    abort = 1'b1; err = 1'b1;
    @(negedge clk);
    abort = 1'b0; err = 1'b0;
    chk("both_status", status, SEQ_ERROR);
    wait_done("both_done");
    $display("seq error_and_abort status=%0d", status);

`ifdef SEQ_TIMEOUT_EN
    ready = 1'b0;
    pulse_start(WRITE_ONLY, 16'h0000, 3, 8'd1);
    c = 0;
    while (!op_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    n = 0;
    while (!done_stb && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_status", status, SEQ_TIMEOUT);
    chk("tmo_valid", op_valid, 0);
    @(negedge clk);
    chk("tmo_busy", busy, 0);
    $display("seq timeout stalled=%0d status=%0d", n, status);
`endif

    // Asynchronous reset in the middle of a pass
    ready = 1'b1;
    pulse_start(WRITE_ONLY, 16'h0800, 8, 8'd1);
    repeat (3) @(negedge clk);
    ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", op_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pkt_done", pkt_done, 0);
    chk("arst_status", status, SEQ_OK);
    chk("arst_done", done_stb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", busy, 0);
    $display("seq async_reset valid=%0b busy=%0b", op_valid, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
